// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types, constants and xtime for the AES round controller
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SUB,
        UPD,
        DONE
    } ctrl_state_t;

    localparam logic [7:0] AES_POLY  = 8'h1B;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         ROUND_W   = 4;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - registered round constant, reloaded on init, advanced by xtime
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcon_q <= RCON_INIT;
        end else if (init) begin
            rcon_q <= RCON_INIT;
        end else if (advance) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer with Moore outputs; AES_CTRL_ABORT_EN adds an abort input
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR       = 10,
    parameter int SBOX_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
`ifdef AES_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               state_we,
    output logic               key_we,
    output logic               init_sel,
    output logic               skip_mix,
    output logic [ROUND_W-1:0] round,
    output logic [7:0]         rcon
);

    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NR);
    localparam logic [1:0]         WAIT_LAST  = 2'(SBOX_LAT == 0 ? 0 : SBOX_LAT - 1);
    localparam bit                 NO_WAIT    = (SBOX_LAT == 0);

    ctrl_state_t        state_q;
    ctrl_state_t        state_d;
    logic [ROUND_W-1:0] round_q;
    logic [1:0]         wait_q;
    logic               last_round;
    logic               abort_req;
    logic               rcon_init;
    logic               rcon_adv;

    assign last_round = (round_q == ROUND_LAST);

`ifdef AES_CTRL_ABORT_EN
    assign abort_req = abort && (state_q inside {INIT, SUB, UPD});
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (load) state_d = INIT;
            INIT:       state_d = NO_WAIT ? UPD : SUB;
            SUB:        if (wait_q == WAIT_LAST) state_d = UPD;
            UPD: begin
                if (last_round) begin
                    state_d = DONE;
                end else begin
                    state_d = NO_WAIT ? UPD : SUB;
                end
            end
            default:    state_d = IDLE;
        endcase
        if (abort_req) begin
            state_d = IDLE;
        end
    end

    // Round index and S-box wait counter; wait_q only counts while in SUB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_q <= '0;
            wait_q  <= '0;
        end else begin
            wait_q <= (state_q == SUB) ? wait_q + 2'd1 : 2'd0;
            if (abort_req) begin
                round_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: if (load) round_q <= '0;
                    INIT:       round_q <= ROUND_W'(1);
                    UPD:        if (!last_round) round_q <= round_q + ROUND_W'(1);
                    default:    round_q <= round_q;
                endcase
            end
        end
    end

    assign rcon_init = (state_q == INIT) || abort_req;
    assign rcon_adv  = (state_q == UPD) && !last_round;

    aes_rcon_gen u_rcon (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (rcon_init),
        .advance (rcon_adv),
        .rcon    (rcon)
    );

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        state_we = 1'b0;
        key_we   = 1'b0;
        init_sel = 1'b0;
        skip_mix = 1'b0;
        case (state_q)
            INIT: begin
                busy     = 1'b1;
                state_we = 1'b1;
                key_we   = 1'b1;
                init_sel = 1'b1;
            end
            SUB:  busy = 1'b1;
            UPD: begin
                busy     = 1'b1;
                state_we = 1'b1;
                key_we   = 1'b1;
                skip_mix = last_round;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed bench with a behavioural AES datapath driven by the controller
module tb_aes_round_ctrl;

    localparam logic [127:0] KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT      = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [17:0]  RST_VEC = {6'b000000, 4'd0, 8'h01};
    localparam logic [17:0]  DONE_VEC = {6'b010000, 4'd10, 8'h36};

    logic       clk;
    logic       reset_n;
    logic       abort;
    logic [2:0] load_v;
    wire  [2:0] done_v;

    wire        busy, done, state_we, key_we, init_sel, skip_mix;
    wire  [3:0] round;
    wire  [7:0] rcon;
    wire        b1, d1, sw1, kw1, is1, sm1;
    wire  [3:0] r1;
    wire  [7:0] rc1;
    wire        b2, d2, sw2, kw2, is2, sm2;
    wire  [3:0] r2;
    wire  [7:0] rc2;

    assign done_v = {d2, d1, done};

    aes_round_ctrl #(.NR(10), .SBOX_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .load(load_v[0]),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .state_we(state_we), .key_we(key_we),
        .init_sel(init_sel), .skip_mix(skip_mix), .round(round), .rcon(rcon)
    );

    aes_round_ctrl #(.NR(10), .SBOX_LAT(0)) dut_lat0 (
        .clk(clk), .reset_n(reset_n), .load(load_v[1]),
`ifdef AES_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .busy(b1), .done(d1), .state_we(sw1), .key_we(kw1),
        .init_sel(is1), .skip_mix(sm1), .round(r1), .rcon(rc1)
    );

    aes_round_ctrl #(.NR(10), .SBOX_LAT(3)) dut_lat3 (
        .clk(clk), .reset_n(reset_n), .load(load_v[2]),
`ifdef AES_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .busy(b2), .done(d2), .state_we(sw2), .key_we(kw2),
        .init_sel(is2), .skip_mix(sm2), .round(r2), .rcon(rc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [17:0] pack0();
        return {busy, done, state_we, key_we, init_sel, skip_mix, round, rcon};
    endfunction
    function automatic logic [17:0] pack1();
        return {b1, d1, sw1, kw1, is1, sm1, r1, rc1};
    endfunction
    function automatic logic [17:0] pack2();
        return {b2, d2, sw2, kw2, is2, sm2, r2, rc2};
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1B; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, base, s, t, e;
        r = 8'h01; base = a; e = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        s = r; t = r;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, tmp;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic skip);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                c0 = t[4*c]; c1 = t[4*c+1]; c2 = t[4*c+2]; c3 = t[4*c+3];
                t[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                t[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                t[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                t[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    // Datapath registers steered only by the controller's enables and selects.
    logic [127:0] st_q, key_q;
    always @(posedge clk) begin
        if (state_we) st_q <= init_sel ? (PT ^ KEY) : aes_round(st_q, key_expand(key_q, rcon), skip_mix);
        if (key_we)   key_q <= init_sel ? KEY : key_expand(key_q, rcon);
    end

    logic       mon_en, mon_clr;
    int         we_cnt, skip_cnt, skip_at, any_cnt;
    logic [7:0] rcon_log [16];
    always @(negedge clk) begin
        if (mon_clr) begin
            we_cnt <= 0; skip_cnt <= 0; skip_at <= -1; any_cnt <= 0;
        end else if (mon_en) begin
            if (state_we) begin
                rcon_log[we_cnt[3:0]] <= rcon;
                we_cnt <= we_cnt + 1;
                if (skip_mix) skip_at <= we_cnt;
            end
            skip_cnt <= skip_cnt + int'(skip_mix);
            if (state_we | key_we | init_sel | skip_mix | busy | done) any_cnt <= any_cnt + 1;
        end
    end

    // Pulses load, then counts edges after E0 until done; extra load pulses at edges a and b.
    task automatic start_run(input int idx, input int a, input int b, output int lat);
        int n;
        load_v[idx] = 1'b1;
        @(posedge clk); #1;
        load_v[idx] = 1'b0;
        n = 0;
        while (!done_v[idx] && n < 200) begin
            @(posedge clk); #1;
            n++;
            load_v[idx] = (n == a || n == b);
        end
        load_v[idx] = 1'b0;
        lat = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        reset_n = 1'b0; load_v = 3'b000; abort = 1'b0; mon_en = 1'b0; mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", pack0(), RST_VEC);
        check("reset_outputs_lat3", pack2(), RST_VEC);
        reset_n = 1'b1; mon_clr = 1'b0; mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("idle_no_enable", any_cnt, 0);
        check("idle_outputs", pack0(), RST_VEC);

        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; mon_en = 1'b1;
        start_run(0, 0, 0, lat);
        mon_en = 1'b0;
        check("nom_latency", lat, 21);
        check("nom_we_pulses", we_cnt, 11);
        check("nom_skip_count", skip_cnt, 1);
        check("nom_skip_on_last", skip_at, 10);
        for (int r = 1; r <= 10; r++)
            check($sformatf("nom_rcon_r%0d", r), rcon_log[r], rcon_ref(r));
        check("nom_ciphertext", st_q, CT);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", pack0(), DONE_VEC);

        start_run(0, 6, 14, lat);
        check("repulse_latency", lat, 21);
        check("repulse_ciphertext", st_q, CT);

        load_v[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("hold_first_latency", n, 21);
        @(posedge clk); #1;
        check("hold_done_one_cycle", done, 1'b0);
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        load_v[0] = 1'b0;
        check("hold_second_latency", n, 21);
        check("hold_ciphertext", st_q, CT);

        load_v[0] = 1'b1;
        @(posedge clk); #1;
        load_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("midrun_busy_before_reset", {busy, round}, {1'b1, 4'd5});
        reset_n = 1'b0;
        #1;
        check("midrun_reset_outputs", pack0(), RST_VEC);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", pack0(), RST_VEC);
        start_run(0, 0, 0, lat);
        check("post_reset_latency", lat, 21);
        check("post_reset_ciphertext", st_q, CT);

`ifdef AES_CTRL_ABORT_EN
        load_v[0] = 1'b1;
        @(posedge clk); #1;
        load_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_outputs", pack0(), RST_VEC);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", pack0(), RST_VEC);
        start_run(0, 0, 0, lat);
        check("abort_rerun_latency", lat, 21);
        check("abort_rerun_ciphertext", st_q, CT);
`endif

        start_run(1, 0, 0, lat);
        check("lat0_latency", lat, 11);
        check("lat0_done_outputs", pack1(), DONE_VEC);
        start_run(2, 0, 0, lat);
        check("lat3_latency", lat, 41);
        check("lat3_done_outputs", pack2(), DONE_VEC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
FSM that sequences the AES-128 encryption datapath: AddRoundKey, SubBytes, ShiftRows, MixColumns and key expansion. It drives the state/key register write enables, mux selects, round counter and Rcon, and owns the load/done handshake toward the SPI-facing top level. It adds no datapath logic. The synchronous S-box latency is parameterised so the same controller fits the registered-RAM S-box used on the FPGA.

Parameters:
NR, 10, number of rounds; final round skips MixColumns.
SBOX_LAT, 1, S-box (and key-expansion S-box) read latency in cycles; legal 0..3.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
load  input  1  start request; sampled only in IDLE or DONE.
busy  output  1  high from INIT through the last UPD.
done  output  1  ciphertext valid; held until next accepted load.
state_we  output  1  state register write enable.
key_we  output  1  round-key register write enable.
init_sel  output  1  1: state <= plaintext ^ key and key reg <= cipher key; 0: round path.
skip_mix  output  1  1: bypass MixColumns (final round).
round  output  4  current round index, 0..NR.
rcon  output  8  round constant for key expansion of current round.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, state_we=0, key_we=0, init_sel=0, skip_mix=0, round=0, rcon=8'h01.
- States: IDLE, INIT, SUB, UPD, DONE.
- IDLE: all enables 0. load=1 at an edge -> INIT.
- INIT (1 cycle): state_we=1, key_we=1, init_sel=1, busy=1, round=0. Next -> SUB with round=1, rcon=8'h01. If SBOX_LAT=0, next -> UPD instead.
- SUB (SBOX_LAT cycles, internal wait counter): busy=1, all enables 0. S-box inputs are stable from the registered state. After the last wait cycle -> UPD.
- UPD (1 cycle): state_we=1, key_we=1, busy=1, skip_mix=(round==NR).
  - If round==NR -> DONE.
  - Otherwise round<=round+1, rcon<=xtime(rcon), then -> SUB, or -> UPD when SBOX_LAT=0.
- xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00). Sequence is 01,02,04,08,10,20,40,80,1B,36.
- DONE: done=1, busy=0, enables 0, round holds NR. load=1 -> INIT; done drops in the same edge. round and rcon reinitialise on entry to SUB.
- Latency: load sampled at edge E0; done high after edge E(1+NR*(SBOX_LAT+1)). With defaults that is E21.
- load while busy (INIT/SUB/UPD) is ignored. The run is not restarted and no request is queued.
- load held high continuously: a new run starts each time DONE is reached. done is then high for exactly one cycle.
- reset_n low mid-run: immediate return to reset values. No partial done is produced.
- Outputs are Moore (decoded from state, round and wait counter only). load never combinationally reaches any output.

Optional Feature:
AES_CTRL_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 while busy -> IDLE at the next edge. done stays 0, no further state_we/key_we, round=0, rcon=8'h01. abort in IDLE or DONE has no effect. When abort and load are high at the same edge in IDLE, load wins.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state enum typedef ctrl_state_t {IDLE, INIT, SUB, UPD, DONE}
  - localparam AES_POLY = 8'h1B
  - localparam RCON_INIT = 8'h01
  - localparam ROUND_W = 4
- One natural sub-module: aes_rcon_gen, the registered Rcon with init/advance inputs and xtime.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all outputs immediately at reset values; release, idle 5 cycles -> no enable ever asserts.
- Nominal run, SBOX_LAT=1, load pulse at E0 -> INIT in cycle after E0; state_we pulses at E1 and every 2nd cycle after, 11 pulses total; skip_mix=1 only on the 11th; done=1 after E21; rcon in UPD = 01,02,04,08,10,20,40,80,1B,36.
- Datapath hookup with FIPS-197 Appendix B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32 when done=1.
- load re-pulsed at rounds 3 and 7 -> ignored; done still after E21 with the same ciphertext.
- reset_n low during round 5 and then a fresh load -> clean run; done after 21 edges from the new load.
- SBOX_LAT=0 -> done after E11; SBOX_LAT=3 -> done after E41.
- With AES_CTRL_ABORT_EN: abort in round 4 -> IDLE next edge, done stays 0; a fresh load then completes normally.
